prim_reg_sw_port: RTL
=====================

// Module: prim_reg_sw_port
//
// PURPOSE
// - SW-facing register access port: takes one bus request at a time (valid/ready, word address, write,
//   wdata, byte mask) and decodes it into per-register write/read pulses for the subreg arbiters.
// - Returns a registered response (rdata, error) and sits between the bus adapter and NumRegs subregs.
// - Drives the we/wd inputs of each subreg arbiter; the RC read-clear pulse goes out on reg_re_o.
//
// PARAMETERS
// - DW        32            register/data width (multiple of 8)
// - AW        8             byte address width; register index = addr_i[AW-1:2]
// - NumRegs   16            number of registers; NumRegs <= 2**(AW-2)
// - RegAccess '{default:RW} sw_access_e [NumRegs], per-register SW access type
//
// PORTS
// - clk_i      in   1           clock
// - rst_ni     in   1           async reset, active low
// - req_i      in   1           request valid
// - gnt_o      out  1           request accepted when req_i & gnt_o
// - addr_i     in   AW          byte address
// - write_i    in   1           1 = write, 0 = read
// - wdata_i    in   DW          write data
// - wmask_i    in   DW/8        byte enables (writes only)
// - rvalid_o   out  1           response valid
// - rready_i   in   1           response accepted when rvalid_o & rready_i
// - rdata_o    out  DW          read data (0 on writes and errors)
// - rerror_o   out  1           response error
// - reg_we_o   out  NumRegs     one-hot write pulse, to the arbiter "we" input
// - reg_re_o   out  NumRegs     one-hot read pulse (RC registers only)
// - reg_wd_o   out  DW          shared write data, to the arbiter "wd" input
// - reg_q_i    in   NumRegs*DW  current register values
//
// BEHAVIOUR
// - Reset: gnt_o=1; rvalid_o, rerror_o, reg_we_o, reg_re_o = 0; rdata_o, reg_wd_o = 0.
// - FSM, 2 states:
//   - IDLE -> RESP on accept.
//   - RESP -> IDLE on rready_i with no new accept.
//   - RESP -> RESP on rready_i with a simultaneous accept (back-to-back, 1 request per cycle).
// - gnt_o = (state==IDLE) | rready_i. Combinational from rready_i only; never depends on req_i.
// - Accept cycle T. In T+1:
//   - exactly one reg_we_o or reg_re_o bit is high for one cycle, or none on error;
//   - rvalid_o=1 and held stable with rdata/rerror until rready_i.
// - Decode errors, each giving no pulse, rerror=1, rdata=0:
//   - addr_i[1:0] != 0;
//   - index >= NumRegs;
//   - write to RO;
//   - read of WO (rerror=0, rdata=0; not an error).
// - Write data, byte mask m expanded per bit:
//   - RW/WO: wd = (wdata & m) | (q & ~m);
//   - W1C/W1S: wd = wdata & m (unmasked bytes are no-op);
//   - W0C: wd = wdata | ~m;
//   - RC: write ignored, no pulse, rerror=0.
// - Reads:
//   - rdata = reg_q_i slice sampled in T, so pre-clear/pre-write value is returned;
//   - RC read asserts reg_re_o[idx] in T+1.
// - Write with wmask_i == 0 still pulses reg_we_o (wd equals q for RW) and responds OK.
// - Reset asserted mid-response: response dropped, all outputs return to reset values asynchronously.
//
// STRUCTURE
// - Package prim_reg_sw_pkg:
//   - typedef enum logic [2:0] sw_access_e {RW, RO, WO, W1C, W1S, W0C, RC};
//   - function mask_expand(DW/8 -> DW).
// - One sub-module, prim_reg_sw_decode (combinational): addr/type -> index, error, read/write class.
// - All state (FSM, response regs, pulse regs, wd reg) lives in the top.
//
// TESTING
// - Reset then idle: gnt_o=1, rvalid_o=0, no pulses; assert rst_ni low mid-RESP -> rvalid_o drops at once.
// - Write RW reg 3, addr 0x0C, wdata 0xA5A5_A5A5, mask 4'b0011, q=0x1234_5678:
//   reg_we_o=16'h0008 for 1 cycle, reg_wd_o=0x1234_A5A5, rvalid next cycle, rerror=0.
// - Read RC reg 5, q=0xDEAD_BEEF:
//   rdata=0xDEAD_BEEF, reg_re_o=16'h0020 for 1 cycle; rready_i held 0 for 3 cycles ->
//   response stable, gnt_o=0.
// - Errors, each rerror=1 with no pulse: addr 0x41 (misaligned); addr 0x40 (index 16 >= NumRegs);
//   write to RO reg 0.
// - Back-to-back: 4 writes with rready_i=1 -> 1 accept/cycle, 4 consecutive single-bit we pulses,
//   responses in order.
// - W1C reg 2, wdata 0xFF, mask 4'b0001 -> reg_wd_o=0x0000_00FF; WO read -> rdata=0, rerror=0.

Source files
------------

// File: rtl/prim_reg_sw_pkg.sv
// Shared types and helpers for the SW register access port.
// Access-type encoding, FSM states and byte-mask expansion.
package prim_reg_sw_pkg;

    typedef enum logic [2:0] {
        RW,
        RO,
        WO,
        W1C,
        W1S,
        W0C,
        RC
    } sw_access_e;

    typedef enum logic {
        IDLE,
        RESP
    } sw_state_e;

    // Widest data path the mask helper supports; callers cast down to DW.
    localparam int unsigned MaxDW = 128;
    localparam int unsigned MaxMW = MaxDW / 8;

    function automatic logic [MaxDW-1:0] mask_expand(input logic [MaxMW-1:0] m);
        logic [MaxDW-1:0] r;
        r = '0;
        for (int b = 0; b < MaxMW; b++) begin
            r[b*8 +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/prim_reg_sw_decode.sv
// Combinational address/access decode: register index, error, and which pulse (if any) to raise.
// Zero latency; no flow control of its own.
module prim_reg_sw_decode
    import prim_reg_sw_pkg::*;
#(
    parameter int unsigned AW                  = 8,
    parameter int unsigned NumRegs             = 16,
    parameter sw_access_e  RegAccess [NumRegs] = '{default: RW}
) (
    input  logic [AW-1:0] addr_i,
    input  logic          write_i,
    output logic [AW-3:0] idx_o,
    output sw_access_e    acc_o,
    output logic          err_o,
    output logic          we_o,
    output logic          re_o,
    output logic          rd_q_o
);

    localparam int unsigned IdxW = AW - 2;

    logic misalign;
    logic in_range;
    logic hit;

    always_comb begin
        idx_o    = addr_i[AW-1:2];
        misalign = |addr_i[1:0];
        in_range = 32'(idx_o) < NumRegs;
        acc_o    = RW;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (idx_o == IdxW'(i)) begin
                acc_o = RegAccess[i];
            end
        end
        hit = in_range && !misalign;

        // RC writes and WO reads are silently accepted, not errors.
        err_o  = !hit || (write_i && (acc_o == RO));
        we_o   = hit && write_i && (acc_o != RO) && (acc_o != RC);
        re_o   = hit && !write_i && (acc_o == RC);
        rd_q_o = hit && !write_i && (acc_o != WO);
    end

endmodule

// File: rtl/prim_reg_sw_port.sv
// SW register port: one bus request at a time -> one-cycle we/re pulse plus registered response.
// Pulses and response appear the cycle after accept; gnt_o = idle | rready_i, so a stalled response blocks new requests.
module prim_reg_sw_port
    import prim_reg_sw_pkg::*;
#(
    parameter int unsigned DW                  = 32,
    parameter int unsigned AW                  = 8,
    parameter int unsigned NumRegs             = 16,
    parameter sw_access_e  RegAccess [NumRegs] = '{default: RW}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [AW-1:0]         addr_i,
    input  logic                  write_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [DW/8-1:0]       wmask_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DW-1:0]         rdata_o,
    output logic                  rerror_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wd_o,
    input  logic [NumRegs*DW-1:0] reg_q_i
);

    localparam int unsigned IdxW = AW - 2;

    sw_state_e            state_q, state_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 rerror_q, rerror_d;
    logic [NumRegs-1:0]   we_q, we_d;
    logic [NumRegs-1:0]   re_q, re_d;
    logic [DW-1:0]        wd_q, wd_d;

    logic [IdxW-1:0]      dec_idx;
    sw_access_e           dec_acc;
    logic                 dec_err;
    logic                 dec_we;
    logic                 dec_re;
    logic                 dec_rd_q;

    logic                 accept;
    logic [DW-1:0]        q_sel;
    logic [DW-1:0]        mask;
    logic [DW-1:0]        wd_new;

    prim_reg_sw_decode #(
        .AW        (AW),
        .NumRegs   (NumRegs),
        .RegAccess (RegAccess)
    ) u_decode (
        .addr_i  (addr_i),
        .write_i (write_i),
        .idx_o   (dec_idx),
        .acc_o   (dec_acc),
        .err_o   (dec_err),
        .we_o    (dec_we),
        .re_o    (dec_re),
        .rd_q_o  (dec_rd_q)
    );

    assign gnt_o  = (state_q == IDLE) | rready_i;
    assign accept = req_i & gnt_o;

    always_comb begin
        q_sel = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (dec_idx == IdxW'(i)) begin
                q_sel = reg_q_i[i*DW +: DW];
            end
        end
    end

    // Arbiters take a full-width value, so masked-off bits carry the neutral value for each type.
    always_comb begin
        mask = DW'(mask_expand(MaxMW'(wmask_i)));
        case (dec_acc)
            RW, WO:   wd_new = (wdata_i & mask) | (q_sel & ~mask);
            W1C, W1S: wd_new = wdata_i & mask;
            W0C:      wd_new = wdata_i | ~mask;
            default:  wd_new = wdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rerror_d = rerror_q;
        we_d     = '0;
        re_d     = '0;
        wd_d     = wd_q;

        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (rready_i && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rerror_d = dec_err;
            rdata_d  = dec_rd_q ? q_sel : '0;
            if (dec_we) begin
                we_d = NumRegs'(1) << dec_idx;
                wd_d = wd_new;
            end
            if (dec_re) begin
                re_d = NumRegs'(1) << dec_idx;
            end
        end else if ((state_q == RESP) && rready_i) begin
            rdata_d  = '0;
            rerror_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            rerror_q <= 1'b0;
            we_q     <= '0;
            re_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rerror_q <= rerror_d;
            we_q     <= we_d;
            re_q     <= re_d;
            wd_q     <= wd_d;
        end
    end

    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rdata_q;
    assign rerror_o = rerror_q;
    assign reg_we_o = we_q;
    assign reg_re_o = re_q;
    assign reg_wd_o = wd_q;

endmodule
